// File: rtl/li_fifo_drain.sv
// -----------------------------------------------------------------------------
// li_fifo_drain
//
// Drains an upstream FIFO whose read data arrives READ_LATENCY cycles after
// the dequeue request, and re-presents the words on a valid/ready interface.
// A small skid buffer (BUF_DEPTH = READ_LATENCY + 2 entries) absorbs words that
// are already in flight when the downstream stalls. Requests are issued only
// while a buffer slot is guaranteed for them. Because of this, full-rate
// streaming needs no look at i_ready, and no word is lost under backpressure.
//
// Ports
//   clock        : sole clock, rising edge
//   reset        : asynchronous, active-low reset (shared with upstream FIFO)
//   i_fifo_data  : upstream FIFO read data, valid READ_LATENCY cycles after deq
//   i_fifo_empty : upstream FIFO empty flag
//   o_fifo_deq   : read request to the upstream FIFO (combinational)
//   o_data       : downstream data word, buffer[rd_ptr]
//   o_valid      : o_data holds a word
//   i_ready      : downstream accepts the word this cycle
//   o_error      : sticky, set when a buffer write was attempted while full
// -----------------------------------------------------------------------------
module li_fifo_drain #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_deq,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_error
);

  localparam int BUF_DEPTH = READ_LATENCY + 2;
  localparam int PTR_W     = $clog2(BUF_DEPTH);
  // Wide enough for count plus every in-flight bit.
  localparam int CNT_W     = $clog2(BUF_DEPTH + READ_LATENCY + 1);

  logic [READ_LATENCY-1:0] in_flight;
  logic [READ_LATENCY-1:0] in_flight_nxt;
  logic [DATA_WIDTH-1:0]   buffer [BUF_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        in_flight_ones;
  logic [CNT_W-1:0]        credits;
  logic                    wr_req;
  logic                    wr_en;
  logic                    xfer;
  logic                    full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits: every word already buffered or still travelling from the FIFO.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    in_flight_ones = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      in_flight_ones = in_flight_ones + CNT_W'(in_flight[i]);
    end
    credits = count + in_flight_ones;
  end

  // Gating with reset keeps the request low while reset is held, even though
  // the upstream FIFO may already look non-empty.
  assign o_fifo_deq = reset && !i_fifo_empty && (credits < CNT_W'(BUF_DEPTH));

  assign o_valid = (count != '0);
  assign o_data  = buffer[rd_ptr];

  assign xfer   = o_valid && i_ready;
  assign full   = (count == CNT_W'(BUF_DEPTH));
  assign wr_req = in_flight[READ_LATENCY-1];
  // When full, a same-cycle transfer frees the slot at rd_ptr (== wr_ptr).
  assign wr_en  = wr_req && (!full || xfer);

  always_comb begin
    in_flight_nxt    = in_flight << 1;
    in_flight_nxt[0] = o_fifo_deq;
  end

  // Control state: pointers, occupancy, in-flight tracking and error flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_flight <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      o_error   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      in_flight <= in_flight_nxt;
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (xfer)  rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, xfer})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_req && full && !xfer) o_error <= 1'b1;
    end
  end

  // NOTE: the data storage has no reset; its contents are only observed
  // through o_data while count != 0, so clearing it would buy nothing.
  always_ff @(posedge clock) begin
    if (wr_en) buffer[wr_ptr] <= i_fifo_data;
  end

endmodule
